// File: rtl/block_store_pkg.sv
// Shared definitions for the brick-state store: default geometry and the
// arbiter FSM state encoding.
package block_store_pkg;

  localparam int NUM_BLOCKS_DEF = 100;
  localparam int ADDR_W_DEF     = 7;
  localparam int CNT_W_DEF      = 7;

  // SWEEP: level-init fill, SERVE: normal arbitration, WPEND: kill write waiting for a free port
  typedef enum logic [1:0] {
    SWEEP = 2'd0,
    SERVE = 2'd1,
    WPEND = 2'd2
  } blk_state_e;

endpackage

// File: rtl/block_store_arbiter_if.sv
// Requester-side bus of the brick store: renderer read channel and
// physics read/read-kill channel. master = requesters, slave = arbiter.
interface block_store_arbiter_if
  import block_store_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_alive;

  logic              phy_req;
  logic [ADDR_W-1:0] phy_addr;
  logic              phy_kill;
  logic              phy_gnt;
  logic              phy_valid;
  logic              phy_alive;

  modport master (
    output vid_req, vid_addr, phy_req, phy_addr, phy_kill,
    input  vid_alive, phy_gnt, phy_valid, phy_alive
  );

  modport slave (
    input  vid_req, vid_addr, phy_req, phy_addr, phy_kill,
    output vid_alive, phy_gnt, phy_valid, phy_alive
  );

endinterface

// File: rtl/block_state_ram.sv
// Single-port 1-bit brick-state memory: synchronous write, registered
// read, no reset (contents are established by the level-init sweep).
module block_state_ram #(
  parameter int DEPTH  = 100,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic              wdata,
  output logic              rdata
);

  logic mem [DEPTH];
  logic rdata_reg;

  // One access per cycle; read data reflects the contents before any same-cycle write
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_reg <= mem[addr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/block_store_arbiter.sv
// Brick-state store arbiter: shares the single-port brick memory between the
// renderer (fixed priority, 1-cycle read latency, never stalls) and physics
// (read / read-kill with grant handshake), and runs the level-init sweep.
// Optional alive counter enabled by defining BLOCK_STORE_COUNT_EN.
module block_store_arbiter
  import block_store_pkg::*;
#(
  parameter int NUM_BLOCKS = NUM_BLOCKS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  level_init,
  output logic                  init_busy,
  block_store_arbiter_if.slave  bus,
  output logic [CNT_W-1:0]      alive_count,
  output logic                  all_cleared
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_BLOCKS - 1);
  localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(NUM_BLOCKS);

  blk_state_e        state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg;
  logic [ADDR_W-1:0] pend_addr_reg;
  logic [ADDR_W-1:0] phy_addr_reg;
  logic              init_busy_reg;
  logic              vid_rd_reg;
  logic              phy_valid_reg;
  logic              phy_kill_reg;
  logic              phy_inr_reg;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic              ram_wdata;
  logic              ram_rdata;

  logic              vid_inr;
  logic              phy_inr;
  logic              enter_wpend;
  logic              fwd_hit;
  logic              sweep_last;
  logic              phy_gnt;
  logic              vid_read;

  block_state_ram #(
    .DEPTH  (NUM_BLOCKS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign vid_inr = ({1'b0, bus.vid_addr} < ADDR_LIMIT);
  assign phy_inr = ({1'b0, bus.phy_addr} < ADDR_LIMIT);

  // The physics read data is on ram_rdata during the PHY_VALID cycle; a live
  // brick with a kill request turns into a pending write.
  assign enter_wpend = (state_reg == SERVE) && phy_valid_reg && phy_kill_reg
                       && phy_inr_reg && ram_rdata;

  // A video read of a brick that is (about to be) killed must already see it dead.
  assign fwd_hit = ((state_reg == WPEND) && (bus.vid_addr == pend_addr_reg)) ||
                   (enter_wpend && (bus.vid_addr == phy_addr_reg));

  // init_busy_reg gates sweep writes so the busy window and the writes line up after reset
  assign sweep_last = init_busy_reg && (ptr_reg == LAST_ADDR);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= SWEEP;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state: LEVEL_INIT overrides everything, including a pending kill
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SWEEP: begin
        if (!level_init && sweep_last) state_next = SERVE;
      end
      SERVE: begin
        if (level_init)       state_next = SWEEP;
        else if (enter_wpend) state_next = WPEND;
      end
      WPEND: begin
        if (level_init)        state_next = SWEEP;
        else if (!bus.vid_req) state_next = SERVE;
      end
      default: state_next = SWEEP;
    endcase
  end

  // FSM outputs: memory port steering, physics grant and video read qualification
  always_comb begin
    ram_addr  = bus.vid_addr;
    ram_we    = 1'b0;
    ram_wdata = 1'b0;
    phy_gnt   = 1'b0;
    vid_read  = bus.vid_req && (state_reg != SWEEP) && vid_inr && !fwd_hit;
    case (state_reg)
      SWEEP: begin
        ram_addr  = ptr_reg;
        ram_we    = init_busy_reg && !level_init;
        ram_wdata = 1'b1;
      end
      SERVE: begin
        if (!bus.vid_req && bus.phy_req && !enter_wpend && !level_init) begin
          phy_gnt  = 1'b1;
          ram_addr = bus.phy_addr;
        end
      end
      WPEND: begin
        if (!bus.vid_req && !level_init) begin
          ram_addr = pend_addr_reg;
          ram_we   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers: sweep pointer, physics request latch, pending-kill address, read tags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_reg       <= '0;
      pend_addr_reg <= '0;
      phy_addr_reg  <= '0;
      init_busy_reg <= 1'b0;
      vid_rd_reg    <= 1'b0;
      phy_valid_reg <= 1'b0;
      phy_kill_reg  <= 1'b0;
      phy_inr_reg   <= 1'b0;
    end else begin
      if (level_init) begin
        ptr_reg <= '0;
      end else if ((state_reg == SWEEP) && init_busy_reg) begin
        ptr_reg <= sweep_last ? '0 : ptr_reg + 1'b1;
      end
      init_busy_reg <= (state_next == SWEEP);
      vid_rd_reg    <= vid_read;
      phy_valid_reg <= phy_gnt;
      if (phy_gnt) begin
        phy_addr_reg <= bus.phy_addr;
        phy_kill_reg <= bus.phy_kill;
        phy_inr_reg  <= phy_inr;
      end
      if (enter_wpend) begin
        pend_addr_reg <= phy_addr_reg;
      end
    end
  end

  assign init_busy     = init_busy_reg;
  assign bus.phy_gnt   = phy_gnt;
  assign bus.phy_valid = phy_valid_reg;
  assign bus.phy_alive = phy_valid_reg && phy_inr_reg && ram_rdata;
  assign bus.vid_alive = vid_rd_reg && ram_rdata;

`ifdef BLOCK_STORE_COUNT_EN
  logic [CNT_W-1:0] count_reg, count_next;
  logic             all_cleared_reg;
  logic             commit;

  assign commit = ram_we && (state_reg == WPEND);

  // Alive counter: zero while sweeping, full on sweep end, minus one per committed kill
  always_comb begin
    count_next = count_reg;
    if (state_next == SWEEP) begin
      count_next = '0;
    end else if (state_reg == SWEEP) begin
      count_next = CNT_W'(NUM_BLOCKS);
    end else if (commit && (count_reg != '0)) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Counter and cleared flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg       <= '0;
      all_cleared_reg <= 1'b0;
    end else begin
      count_reg       <= count_next;
      all_cleared_reg <= (count_next == '0) && (state_next != SWEEP);
    end
  end

  assign alive_count = count_reg;
  assign all_cleared = all_cleared_reg;
`else
  assign alive_count = '0;
  assign all_cleared = 1'b0;
`endif

endmodule
